// File: rtl/mv_pkg.sv
// Shared definitions for the game input sequencer: direction codes, key bit
// positions, FSM state encoding and the direction priority encoder.
package mv_pkg;

    localparam int unsigned DIR_W = 3;
    localparam int unsigned KEY_N = 4;

    localparam logic [DIR_W-1:0] DIR_UP    = 3'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd3;
    localparam logic [DIR_W-1:0] DIR_NONE  = 3'd7;

    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_MAP  = 3'd1,
        S_IDLE = 3'd2,
        S_MOVE = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    // Simultaneous presses resolve up > down > left > right.
    function automatic logic [DIR_W-1:0] dir_from_press(input logic [KEY_N-1:0] p);
        if (p[KEY_UP])         return DIR_UP;
        else if (p[KEY_DOWN])  return DIR_DOWN;
        else if (p[KEY_LEFT])  return DIR_LEFT;
        else if (p[KEY_RIGHT]) return DIR_RIGHT;
        else                   return DIR_NONE;
    endfunction

endpackage

// File: rtl/mv_input_sequencer_if.sv
// Button and request/acknowledge signals between the game top level and the
// input sequencer.
//   keys/redraw      raw active-low buttons
//   doneRedraw       map drawer completion pulse
//   doneMove         sprite stage completion pulse
//   drawMap/move/dir requests to the top level, busy = sequencer not idle
interface mv_input_sequencer_if;

    logic [mv_pkg::KEY_N-1:0] keys;
    logic                     redraw;
    logic                     doneRedraw;
    logic                     doneMove;
    logic                     drawMap;
    logic                     move;
    logic [mv_pkg::DIR_W-1:0] dir;
    logic                     busy;

    modport master (
        output keys, redraw, doneRedraw, doneMove,
        input  drawMap, move, dir, busy
    );

    modport slave (
        input  keys, redraw, doneRedraw, doneMove,
        output drawMap, move, dir, busy
    );

endinterface

// File: rtl/mv_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low button.
//   raw_n  raw button (0 = pressed)
//   level  debounced level (1 = pressed)
//   press  one-cycle pulse on the debounced released->pressed edge
module mv_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q,  prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchroniser flops reset to "released" so reset exit never looks like a press.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Level follows the synchronised input only after DEBOUNCE_CYCLES disagreeing cycles in a row.
    always_comb begin
        sync1_d = raw_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        if (~sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/mv_input_sequencer.sv
// Game front-end controller: conditions the four direction buttons and the
// redraw button, then sequences drawMap / move / dir towards the top level.
//   clock, resetn  clock and async active-low reset
//   bus            button inputs, completion pulses and registered requests
module mv_input_sequencer
    import mv_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MOVE_TIMEOUT    = 65535
) (
    input  logic                  clock,
    input  logic                  resetn,
    mv_input_sequencer_if.slave   bus
);

    localparam int unsigned TMO_W = (MOVE_TIMEOUT < 1) ? 1 : $clog2(MOVE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOVE_TIMEOUT);

    logic [KEY_N-1:0] key_level;
    logic [KEY_N-1:0] key_pulse;
    logic [KEY_N-1:0] key_press;
    logic             redraw_level;
    logic             redraw_pulse;
    logic             redraw_press;

    state_e           state_q,       state_d;
    logic [DIR_W-1:0] dir_q,         dir_d;
    logic             drawmap_q,     drawmap_d;
    logic             move_q,        move_d;
    logic             busy_q,        busy_d;
    logic             pend_valid_q,  pend_valid_d;
    logic [DIR_W-1:0] pend_dir_q,    pend_dir_d;
    logic             redraw_pend_q, redraw_pend_d;
    logic [TMO_W-1:0] tmo_q,         tmo_d;
    logic             dir_taken;

    for (genvar gi = 0; gi < KEY_N; gi++) begin : g_key
        mv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clock  (clock),
            .resetn (resetn),
            .raw_n  (bus.keys[gi]),
            .level  (key_level[gi]),
            .press  (key_pulse[gi])
        );
    end

    mv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_redraw (
        .clock  (clock),
        .resetn (resetn),
        .raw_n  (bus.redraw),
        .level  (redraw_level),
        .press  (redraw_pulse)
    );

    // Drop a pulse whose button has already been released again (only reachable with a 1-cycle debounce).
    assign key_press    = key_pulse & key_level;
    assign redraw_press = redraw_pulse & redraw_level;

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_INIT;
            dir_q         <= DIR_NONE;
            drawmap_q     <= 1'b0;
            move_q        <= 1'b0;
            busy_q        <= 1'b1;
            pend_valid_q  <= 1'b0;
            pend_dir_q    <= DIR_NONE;
            redraw_pend_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            drawmap_q     <= drawmap_d;
            move_q        <= move_d;
            busy_q        <= busy_d;
            pend_valid_q  <= pend_valid_d;
            pend_dir_q    <= pend_dir_d;
            redraw_pend_q <= redraw_pend_d;
            tmo_q         <= tmo_d;
        end
    end

    // Next state, request buffering and registered output decode.
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        pend_valid_d  = pend_valid_q;
        pend_dir_d    = pend_dir_q;
        redraw_pend_d = redraw_pend_q;
        tmo_d         = tmo_q;
        dir_taken     = 1'b0;

        case (state_q)
            S_INIT: state_d = S_MAP;
            // Every request is followed by S_GAP so the top level sees a falling edge.
            S_MAP: begin
                if (bus.doneRedraw) state_d = S_GAP;
            end
            S_IDLE: begin
                if (redraw_pend_q || redraw_press) begin
                    state_d       = S_MAP;
                    redraw_pend_d = 1'b0;
                end else if (pend_valid_q) begin
                    state_d      = S_MOVE;
                    dir_d        = pend_dir_q;
                    pend_valid_d = 1'b0;
                    tmo_d        = '0;
                end else if (|key_press) begin
                    state_d   = S_MOVE;
                    dir_d     = dir_from_press(key_press);
                    dir_taken = 1'b1;
                    tmo_d     = '0;
                end
            end
            S_MOVE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.doneMove || tmo_q == TMO_LAST) state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        // Presses not serviced this cycle are remembered; the newest direction wins.
        if (redraw_press && state_q != S_IDLE) redraw_pend_d = 1'b1;
        if ((|key_press) && !dir_taken) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dir_from_press(key_press);
        end

        drawmap_d = (state_d == S_MAP);
        move_d    = (state_d == S_MOVE);
        busy_d    = (state_d != S_IDLE);
    end

    assign bus.drawMap = drawmap_q;
    assign bus.move    = move_q;
    assign bus.dir     = dir_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mv_input_sequencer.sv
// Self-checking bench for mv_input_sequencer with a short debounce and timeout.
module tb_mv_input_sequencer;
    import mv_pkg::*;

    localparam int unsigned DEB = 8;
    localparam int unsigned TMO = 20;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    mv_input_sequencer_if bus_if ();

    mv_input_sequencer #(.DEBOUNCE_CYCLES(DEB), .MOVE_TIMEOUT(TMO)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_if)
    );

    int n_total = 0;
    int n_pass  = 0;
    int move_rises = 0;
    logic prev_move = 1'b0;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] exp_dir;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: highest-priority key is the lowest set bit of the pressed mask.
    function automatic int ref_dir(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 7;
    endfunction

    // Count move requests and check drawMap/move exclusion every active cycle.
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (bus_if.move && !prev_move) move_rises++;
            if (bus_if.move || bus_if.drawMap)
                check("exclusive", int'(bus_if.move & bus_if.drawMap), 0);
            prev_move = bus_if.move;
        end else begin
            prev_move = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_flag(input string name, input bit want_map);
        int n = 0;
        while (((want_map ? bus_if.drawMap : bus_if.move) !== 1'b1) && n < 60) begin
            tick();
            n++;
        end
        check(name, int'(want_map ? bus_if.drawMap : bus_if.move), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus_if.busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check(name, int'(bus_if.busy), 0);
    endtask

    task automatic done_move(input string name);
        bus_if.doneMove = 1'b1;
        tick();
        bus_if.doneMove = 1'b0;
        check(name, int'(bus_if.move), 0);
    endtask

    task automatic done_redraw();
        bus_if.doneRedraw = 1'b1;
        tick();
        bus_if.doneRedraw = 1'b0;
    endtask

    initial begin
        int r0;
        int n;
        int delay;
        logic [3:0] mask;

        vecs[0] = '{4'b0001, DIR_UP};
        vecs[1] = '{4'b0010, DIR_DOWN};
        vecs[2] = '{4'b0100, DIR_LEFT};
        vecs[3] = '{4'b1000, DIR_RIGHT};
        vecs[4] = '{4'b1001, DIR_UP};
        vecs[5] = '{4'b0110, DIR_DOWN};
        vecs[6] = '{4'b1100, DIR_LEFT};
        vecs[7] = '{4'b1111, DIR_UP};
        vecs[8] = '{4'b1010, DIR_DOWN};

        resetn            = 1'b0;
        bus_if.keys       = 4'hF;
        bus_if.redraw     = 1'b1;
        bus_if.doneRedraw = 1'b0;
        bus_if.doneMove   = 1'b0;
        tick(3);

        // Reset values, then map draw after release.
        check("reset drawMap", int'(bus_if.drawMap), 0);
        check("reset move",    int'(bus_if.move), 0);
        check("reset dir",     int'(bus_if.dir), 7);
        check("reset busy",    int'(bus_if.busy), 1);
        resetn = 1'b1;
        #1;
        check("drawMap cycle 1", int'(bus_if.drawMap), 0);
        tick();
        check("drawMap cycle 2", int'(bus_if.drawMap), 1);
        check("move during map", int'(bus_if.move), 0);
        check("dir after reset", int'(bus_if.dir), 7);
        tick(2);
        done_redraw();
        check("drawMap release", int'(bus_if.drawMap), 0);
        check("busy in gap",     int'(bus_if.busy), 1);
        tick();
        check("busy idle", int'(bus_if.busy), 0);

        // Bouncing left key never qualifies; a clean hold does, with exact latency.
        r0 = move_rises;
        for (int i = 0; i < 40; i++) begin
            bus_if.keys[KEY_LEFT] = ((i / 3) % 2) != 0;
            tick();
        end
        tick(5);
        check("bounce no move", move_rises - r0, 0);
        bus_if.keys[KEY_LEFT] = 1'b0;
        tick(DEB + 3);
        check("press latency early", int'(bus_if.move), 0);
        tick();
        check("press latency move", int'(bus_if.move), 1);
        check("press latency dir",  int'(bus_if.dir), 2);
        bus_if.keys = 4'hF;
        tick(DEB + 4);
        done_move("debounce release");
        wait_idle("debounce idle");
        tick(DEB + 4);

        // Table: single and simultaneous presses give exactly one request.
        foreach (vecs[v]) begin
            r0 = move_rises;
            bus_if.keys = ~vecs[v].mask;
            wait_flag("table move", 1'b0);
            check("table dir", int'(bus_if.dir), int'(vecs[v].exp_dir));
            bus_if.keys = 4'hF;
            tick(DEB + 4);
            check("table move held", int'(bus_if.move), 1);
            done_move("table release");
            wait_idle("table idle");
            tick(DEB + 6);
            check("table one request", move_rises - r0, 1);
        end

        // Buffering: down then left during a right move; only left follows.
        r0 = move_rises;
        bus_if.keys = ~4'b1000;
        wait_flag("buf move", 1'b0);
        check("buf first dir", int'(bus_if.dir), 3);
        bus_if.keys = ~4'b0010;
        tick(3);
        bus_if.keys = ~4'b0110;
        tick(13);
        check("buf still moving", int'(bus_if.move), 1);
        check("buf dir stable",   int'(bus_if.dir), 3);
        done_move("buf N+1 move low");
        tick();
        check("buf N+2 move low", int'(bus_if.move), 0);
        tick();
        check("buf N+3 move", int'(bus_if.move), 1);
        check("buf N+3 dir",  int'(bus_if.dir), 2);
        bus_if.keys = 4'hF;
        tick(DEB + 4);
        done_move("buf second release");
        wait_idle("buf idle");
        tick(DEB + 6);
        check("buf request count", move_rises - r0, 2);

        // Timeout: move held without doneMove.
        bus_if.keys = ~4'b0001;
        wait_flag("tmo move", 1'b0);
        check("tmo dir", int'(bus_if.dir), 0);
        bus_if.keys = 4'hF;
        n = 0;
        while (bus_if.move === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("tmo high cycles", n, int'(TMO) + 1);
        tick();
        check("tmo busy idle", int'(bus_if.busy), 0);
        tick(DEB + 4);

        // Redraw pressed during a move runs after it; reset mid-map drops a buffered press.
        bus_if.keys = ~4'b1000;
        wait_flag("rd move", 1'b0);
        bus_if.keys   = 4'hF;
        bus_if.redraw = 1'b0;
        tick(14);
        check("rd no map yet", int'(bus_if.drawMap), 0);
        done_move("rd move release");
        check("rd N+1 map", int'(bus_if.drawMap), 0);
        tick();
        check("rd N+2 map", int'(bus_if.drawMap), 0);
        tick();
        check("rd N+3 map", int'(bus_if.drawMap), 1);
        bus_if.redraw = 1'b1;
        bus_if.keys   = ~4'b0001;
        tick(DEB + 6);
        check("rd map held", int'(bus_if.drawMap), 1);
        r0 = move_rises;
        bus_if.keys = 4'hF;
        resetn = 1'b0;
        #1;
        check("async drawMap", int'(bus_if.drawMap), 0);
        check("async busy",    int'(bus_if.busy), 1);
        check("async dir",     int'(bus_if.dir), 7);
        tick(2);
        resetn = 1'b1;
        tick();
        check("post reset map", int'(bus_if.drawMap), 1);
        tick(2);
        done_redraw();
        wait_idle("post reset idle");
        tick(DEB + 10);
        check("pending lost", move_rises - r0, 0);
        check("post reset move", int'(bus_if.move), 0);

        // Random presses, optional redraws and random acknowledge delays.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus_if.redraw = 1'b0;
                wait_flag("rand map", 1'b1);
                bus_if.redraw = 1'b1;
                tick($urandom_range(0, 5));
                done_redraw();
                check("rand map release", int'(bus_if.drawMap), 0);
                wait_idle("rand map idle");
                tick(DEB + 4);
            end
            mask  = 4'($urandom_range(1, 15));
            delay = int'($urandom_range(0, 30));
            r0 = move_rises;
            bus_if.keys = ~mask;
            wait_flag("rand move", 1'b0);
            check("rand dir", int'(bus_if.dir), ref_dir(mask));
            bus_if.keys = 4'hF;
            n = 0;
            while (bus_if.move === 1'b1 && n < 60) begin
                if (n == delay) bus_if.doneMove = 1'b1;
                tick();
                bus_if.doneMove = 1'b0;
                n++;
            end
            check("rand high cycles", n, ((delay < int'(TMO)) ? delay : int'(TMO)) + 1);
            wait_idle("rand idle");
            tick(DEB + 6);
            check("rand one request", move_rises - r0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
